// File: rtl/overlay_target_scheduler_pkg.sv
// Shared definitions for the overlay target scheduler: FSM and class
// encodings, label colours, box field layout and small decode helpers.
package overlay_target_scheduler_pkg;

   localparam int CNT_W   = 20;
   localparam int BOX_W   = 48;
   localparam int COORD_W = 12;

   // Field offsets inside one packed {hl,hr,vl,vr} box
   localparam int BOX_HL_LSB = 36;
   localparam int BOX_HR_LSB = 24;
   localparam int BOX_VL_LSB = 12;
   localparam int BOX_VR_LSB = 0;

   localparam logic [23:0] COL_RED = 24'hff0000;
   localparam logic [23:0] COL_GRN = 24'h00ff00;
   localparam logic [23:0] COL_BLU = 24'h0000ff;

   typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_LOCKED, ST_COAST} state_t;
   typedef enum logic [1:0] {CLS_NONE, CLS_RED, CLS_GRN, CLS_BLU} class_t;

   function automatic logic [COORD_W-1:0] box_field(input logic [BOX_W-1:0] box, input int lsb);
      return box[lsb +: COORD_W];
   endfunction

   function automatic logic [23:0] class_colour(input class_t cls);
      case (cls)
         CLS_RED: return COL_RED;
         CLS_GRN: return COL_GRN;
         CLS_BLU: return COL_BLU;
         default: return 24'h000000;
      endcase
   endfunction

   // Enables are packed {b,g,r}
   function automatic logic [2:0] class_onehot(input class_t cls);
      case (cls)
         CLS_RED: return 3'b001;
         CLS_GRN: return 3'b010;
         CLS_BLU: return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] val);
      return (val == 4'hf) ? val : val + 4'd1;
   endfunction

endpackage

// File: rtl/overlay_target_scheduler_if.sv
// Detector-to-overlay bus of the target scheduler. The slave side is the
// scheduler; the master side is the detectors plus the overlay sink.
interface overlay_target_scheduler_if;
   import overlay_target_scheduler_pkg::*;

   logic                 i_vsync;
   logic [2:0]           det_vld;
   logic [3*CNT_W-1:0]   det_cnt;
   logic [3*BOX_W-1:0]   det_box;
   logic [2:0]           det_ack;
   logic                 red_en;
   logic                 grenn_en;
   logic                 blue_en;
   logic [COORD_W-1:0]   hcount_l;
   logic [COORD_W-1:0]   hcount_r;
   logic [COORD_W-1:0]   vcount_l;
   logic [COORD_W-1:0]   vcount_r;
   logic [23:0]          r_t;
   logic                 locked;

   modport slave (
      input  i_vsync, det_vld, det_cnt, det_box,
      output det_ack, red_en, grenn_en, blue_en,
             hcount_l, hcount_r, vcount_l, vcount_r, r_t, locked
   );

   modport master (
      output i_vsync, det_vld, det_cnt, det_box,
      input  det_ack, red_en, grenn_en, blue_en,
             hcount_l, hcount_r, vcount_l, vcount_r, r_t, locked
   );

endinterface

// File: rtl/overlay_target_scheduler_max3_select.sv
// Qualifies the three detector results and picks the largest pixel count.
// Equal counts resolve to the lower index, i.e. red > green > blue.
module ovl_max3_select
   import overlay_target_scheduler_pkg::*;
#(
   parameter logic [CNT_W-1:0] MIN_PIX = 20'd400
) (
   input  logic [2:0]         vld,
   input  logic [3*CNT_W-1:0] cnt,
   input  logic [3*BOX_W-1:0] box,
   output class_t             win,
   output logic [1:0]         idx
);

   logic [2:0]       qual_s;
   logic             found_s;
   logic [CNT_W-1:0] best_s;
   logic [CNT_W-1:0] cnt_s;
   logic [BOX_W-1:0] box_s;

   // Qualify each detector and keep the strictly-largest count seen so far
   always_comb begin
      qual_s  = 3'b000;
      found_s = 1'b0;
      best_s  = {CNT_W{1'b0}};
      idx     = 2'd0;
      cnt_s   = {CNT_W{1'b0}};
      box_s   = {BOX_W{1'b0}};
      for (int i = 0; i < 3; i++) begin
         cnt_s     = cnt[i*CNT_W +: CNT_W];
         box_s     = box[i*BOX_W +: BOX_W];
         qual_s[i] = vld[i] && (cnt_s >= MIN_PIX)
                   && (box_field(box_s, BOX_HL_LSB) < box_field(box_s, BOX_HR_LSB))
                   && (box_field(box_s, BOX_VL_LSB) < box_field(box_s, BOX_VR_LSB));
         if (qual_s[i] && (!found_s || (cnt_s > best_s))) begin
            found_s = 1'b1;
            best_s  = cnt_s;
            idx     = 2'(i);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Map the winning index onto the class encoding
   always_comb begin
      case (idx)
         2'd0:    win = found_s ? CLS_RED : CLS_NONE;
         2'd1:    win = found_s ? CLS_GRN : CLS_NONE;
         default: win = found_s ? CLS_BLU : CLS_NONE;
      endcase
   end

endmodule

// File: rtl/overlay_target_scheduler.sv
// Per-frame overlay target scheduler: samples the detectors on each vsync
// boundary, debounces the winner over LOCK_N frames and coasts the box through
// up to MISS_N-1 empty frames. Outputs are registered and only move at B+2.
module overlay_target_scheduler
   import overlay_target_scheduler_pkg::*;
#(
   parameter logic [CNT_W-1:0] MIN_PIX   = 20'd400,
   parameter int               LOCK_N    = 3,
   parameter int               MISS_N    = 4,
   parameter logic             VS_ACTIVE = 1'b1
) (
   input logic                     pixelclk,
   input logic                     reset,
   overlay_target_scheduler_if.slave bus
);

   logic               vs_r, p1_r, p2_r, bnd_s;
   logic [2:0]         snap_vld_r, det_ack_r;
   logic [3*CNT_W-1:0] snap_cnt_r;
   logic [3*BOX_W-1:0] snap_box_r;
   class_t             win_s;
   logic [1:0]         idx_s;
   logic [BOX_W-1:0]   sel_box_s;

   state_t             state_r, state_nx;
   class_t             cls_r, cls_nx;
   logic [3:0]         lock_r, lock_nx, miss_r, miss_nx;
   logic [BOX_W-1:0]   box_r, box_nx;
   logic               on_s;

   logic [2:0]         en_r;
   logic [BOX_W-1:0]   coord_r;
   logic [23:0]        rt_r;
   logic               locked_r;

   // A new boundary is ignored while the previous one is still in the pipeline
   assign bnd_s = (vs_r != VS_ACTIVE) && (bus.i_vsync == VS_ACTIVE) && !p1_r && !p2_r;

   // Boundary detect, pipeline tracking, detector acknowledge and snapshot
   always_ff @(posedge pixelclk) begin
      if (reset) begin
         vs_r       <= VS_ACTIVE;
         p1_r       <= 1'b0;
         p2_r       <= 1'b0;
         det_ack_r  <= 3'b000;
         snap_vld_r <= 3'b000;
         snap_cnt_r <= {(3*CNT_W){1'b0}};
         snap_box_r <= {(3*BOX_W){1'b0}};
      end else begin
         vs_r      <= bus.i_vsync;
         p1_r      <= bnd_s;
         p2_r      <= p1_r;
         det_ack_r <= bnd_s ? bus.det_vld : 3'b000;
         if (bnd_s) begin
            snap_vld_r <= bus.det_vld;
            snap_cnt_r <= bus.det_cnt;
            snap_box_r <= bus.det_box;
         end
      end
   end

   ovl_max3_select #(.MIN_PIX(MIN_PIX)) u_sel (
      .vld (snap_vld_r),
      .cnt (snap_cnt_r),
      .box (snap_box_r),
      .win (win_s),
      .idx (idx_s)
   );

   // Pick the winning detector's box out of the snapshot
   always_comb begin
      case (idx_s)
         2'd0:    sel_box_s = snap_box_r[0*BOX_W +: BOX_W];
         2'd1:    sel_box_s = snap_box_r[1*BOX_W +: BOX_W];
         default: sel_box_s = snap_box_r[2*BOX_W +: BOX_W];
      endcase
   end

   // Debounce FSM; steps once per frame when the snapshot is evaluated (B+1)
   always_comb begin
      state_nx = state_r;
      cls_nx   = cls_r;
      lock_nx  = lock_r;
      miss_nx  = miss_r;
      box_nx   = box_r;
      if (p1_r) begin
         if ((win_s != CLS_NONE) && (win_s == cls_r) && (state_r != ST_IDLE)) begin
            // Same class again: count towards lock, or refresh a shown box
            box_nx  = sel_box_s;
            miss_nx = 4'd0;
            lock_nx = (state_r == ST_CAND) ? sat_inc(lock_r) : lock_r;
            if (state_r == ST_CAND) begin
               state_nx = (sat_inc(lock_r) >= 4'(LOCK_N)) ? ST_LOCKED : ST_CAND;
            end else begin
               state_nx = ST_LOCKED;
            end
         end else if (win_s != CLS_NONE) begin
            // New class: restart the candidate run
            cls_nx   = win_s;
            box_nx   = sel_box_s;
            lock_nx  = 4'd1;
            miss_nx  = 4'd0;
            state_nx = (LOCK_N <= 1) ? ST_LOCKED : ST_CAND;
         end else begin
            case (state_r)
               ST_LOCKED, ST_COAST: begin
                  miss_nx  = (state_r == ST_LOCKED) ? 4'd1 : sat_inc(miss_r);
                  state_nx = ST_COAST;
                  if (miss_nx >= 4'(MISS_N)) begin
                     state_nx = ST_IDLE;
                     cls_nx   = CLS_NONE;
                     lock_nx  = 4'd0;
                     miss_nx  = 4'd0;
                  end else begin
                     cls_nx   = cls_r;
                  end
               end
               default: begin
                  state_nx = ST_IDLE;
                  cls_nx   = CLS_NONE;
                  lock_nx  = 4'd0;
                  miss_nx  = 4'd0;
               end
            endcase
         end
      end else begin
         state_nx = state_r;
      end
   end

   assign on_s = (state_nx == ST_LOCKED) || (state_nx == ST_COAST);

   // FSM state, counters and registered overlay outputs
   always_ff @(posedge pixelclk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         cls_r    <= CLS_NONE;
         lock_r   <= 4'd0;
         miss_r   <= 4'd0;
         box_r    <= {BOX_W{1'b0}};
         en_r     <= 3'b000;
         coord_r  <= {BOX_W{1'b0}};
         rt_r     <= 24'h000000;
         locked_r <= 1'b0;
      end else begin
         state_r  <= state_nx;
         cls_r    <= cls_nx;
         lock_r   <= lock_nx;
         miss_r   <= miss_nx;
         box_r    <= box_nx;
         en_r     <= on_s ? class_onehot(cls_nx) : 3'b000;
         coord_r  <= on_s ? box_nx : {BOX_W{1'b0}};
         rt_r     <= on_s ? class_colour(cls_nx) : 24'h000000;
         locked_r <= on_s;
      end
   end

   assign bus.det_ack  = det_ack_r;
   assign bus.red_en   = en_r[0];
   assign bus.grenn_en = en_r[1];
   assign bus.blue_en  = en_r[2];
   assign bus.hcount_l = box_field(coord_r, BOX_HL_LSB);
   assign bus.hcount_r = box_field(coord_r, BOX_HR_LSB);
   assign bus.vcount_l = box_field(coord_r, BOX_VL_LSB);
   assign bus.vcount_r = box_field(coord_r, BOX_VR_LSB);
   assign bus.r_t      = rt_r;
   assign bus.locked   = locked_r;

endmodule

// File: tb/tb_overlay_target_scheduler.sv
// Bench for overlay_target_scheduler: directed frame scenarios followed by
// randomized frames, all checked against a frame-level reference model.
module tb_overlay_target_scheduler;
   import overlay_target_scheduler_pkg::*;

   localparam logic [19:0] MIN_PIX = 20'd400;
   localparam int LOCK_N = 3;
   localparam int MISS_N = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   overlay_target_scheduler_if bus_if ();

   overlay_target_scheduler #(.MIN_PIX(MIN_PIX), .LOCK_N(LOCK_N), .MISS_N(MISS_N), .VS_ACTIVE(1'b1)) dut (
      .pixelclk (clk),
      .reset    (reset),
      .bus      (bus_if)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // frame stimulus (index 0=red, 1=green, 2=blue)
   logic [2:0]  f_vld = 3'b000;
   logic [19:0] f_cnt [3];
   logic [11:0] f_hl [3], f_hr [3], f_vl [3], f_vr [3];

   // reference model: shown box/class, pending candidate and run lengths
   bit          m_shown = 1'b0;
   int          m_cls = 0, m_cand = 0, m_streak = 0, m_miss = 0;
   logic [47:0] m_box = 48'h0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_shown = 1'b0; m_cls = 0; m_cand = 0; m_streak = 0; m_miss = 0; m_box = 48'h0;
   endtask

   function automatic int ref_winner(output int idx);
      int best = -1;
      int w = 0;
      idx = 0;
      for (int i = 0; i < 3; i++) begin
         if (f_vld[i] && f_cnt[i] >= MIN_PIX && f_hl[i] < f_hr[i] && f_vl[i] < f_vr[i]
             && int'(f_cnt[i]) > best) begin
            best = int'(f_cnt[i]);
            w    = i + 1;
            idx  = i;
         end
      end
      return w;
   endfunction

   task automatic model_frame();
      int idx;
      int w;
      logic [47:0] wb;
      w  = ref_winner(idx);
      wb = {f_hl[idx], f_hr[idx], f_vl[idx], f_vr[idx]};
      if (w != 0) begin
         if (m_shown && w == m_cls) begin
            m_miss = 0;
            m_box  = wb;
         end else begin
            if (m_shown) begin
               m_shown = 1'b0; m_cand = w; m_streak = 1;
            end else if (w == m_cand) begin
               m_streak++;
            end else begin
               m_cand = w; m_streak = 1;
            end
            if (m_streak >= LOCK_N) begin
               m_shown = 1'b1; m_cls = w; m_box = wb; m_miss = 0;
            end
         end
      end else if (m_shown) begin
         m_miss++;
         if (m_miss >= MISS_N) begin
            m_shown = 1'b0; m_cand = 0; m_streak = 0;
         end
      end else begin
         m_cand = 0; m_streak = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [2:0]  e_en = 3'b000;
      logic [23:0] e_rt = 24'h0;
      logic [47:0] e_box = 48'h0;
      if (m_shown) begin
         e_box = m_box;
         case (m_cls)
            1: begin e_en = 3'b001; e_rt = 24'hff0000; end
            2: begin e_en = 3'b010; e_rt = 24'h00ff00; end
            default: begin e_en = 3'b100; e_rt = 24'h0000ff; end
         endcase
      end
      check_val({tag, ".en"}, 64'({bus_if.blue_en, bus_if.grenn_en, bus_if.red_en}), 64'(e_en));
      check_val({tag, ".box"}, 64'({bus_if.hcount_l, bus_if.hcount_r, bus_if.vcount_l, bus_if.vcount_r}), 64'(e_box));
      check_val({tag, ".r_t"}, 64'(bus_if.r_t), 64'(e_rt));
      check_val({tag, ".locked"}, 64'(bus_if.locked), 64'(m_shown));
   endtask

   task automatic clear_det();
      f_vld = 3'b000;
      for (int i = 0; i < 3; i++) begin
         f_cnt[i] = 20'd0; f_hl[i] = 12'd0; f_hr[i] = 12'd0; f_vl[i] = 12'd0; f_vr[i] = 12'd0;
      end
   endtask

   task automatic set_det(input int i, input logic v, input logic [19:0] c,
                          input logic [11:0] hl, input logic [11:0] hr,
                          input logic [11:0] vl, input logic [11:0] vr);
      f_vld[i] = v; f_cnt[i] = c; f_hl[i] = hl; f_hr[i] = hr; f_vl[i] = vl; f_vr[i] = vr;
   endtask

   task automatic apply_inputs();
      bus_if.det_vld = f_vld;
      bus_if.det_cnt = {f_cnt[2], f_cnt[1], f_cnt[0]};
      bus_if.det_box = {f_hl[2], f_hr[2], f_vl[2], f_vr[2],
                        f_hl[1], f_hr[1], f_vl[1], f_vr[1],
                        f_hl[0], f_hr[0], f_vl[0], f_vr[0]};
   endtask

   task automatic scramble_inputs();
      bus_if.det_vld = 3'($urandom);
      bus_if.det_cnt = 60'({$urandom, $urandom});
      bus_if.det_box = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
   endtask

   // one frame: low vsync with stable inputs, boundary, checks at B+1 and B+2
   task automatic run_frame(input string tag);
      @(negedge clk);
      bus_if.i_vsync = 1'b0;
      apply_inputs();
      repeat (3) @(negedge clk);
      bus_if.i_vsync = 1'b1;
      model_frame();
      @(negedge clk);
      check_val({tag, ".ack"}, 64'(bus_if.det_ack), 64'(f_vld));
      scramble_inputs();
      @(negedge clk);
      check_outputs(tag);
      repeat (3) @(negedge clk);
      check_outputs({tag, ".hold"});
      check_val({tag, ".ack_idle"}, 64'(bus_if.det_ack), 64'd0);
   endtask

   initial begin
      int fav;
      int hl, vl;
      bus_if.i_vsync = 1'b0;
      clear_det();
      apply_inputs();

      // reset state
      repeat (3) @(negedge clk);
      check_outputs("reset");
      check_val("reset.ack", 64'(bus_if.det_ack), 64'd0);
      reset = 1'b0;

      // 1: red locks on the third boundary
      set_det(0, 1'b1, 20'd1000, 12'd100, 12'd300, 12'd50, 12'd200);
      run_frame("t1.f1");
      check_val("t1.f1.red_en", 64'(bus_if.red_en), 64'd0);
      run_frame("t1.f2");
      run_frame("t1.f3");
      check_val("t1.red_en", 64'(bus_if.red_en), 64'd1);
      check_val("t1.hl", 64'(bus_if.hcount_l), 64'd100);
      check_val("t1.hr", 64'(bus_if.hcount_r), 64'd300);
      check_val("t1.vl", 64'(bus_if.vcount_l), 64'd50);
      check_val("t1.vr", 64'(bus_if.vcount_r), 64'd200);
      check_val("t1.r_t", 64'(bus_if.r_t), 64'hff0000);

      // 2: coast through 3 empty frames, recover, then drop after 4
      clear_det();
      for (int k = 0; k < 3; k++) run_frame("t2.coast");
      check_val("t2.coast_locked", 64'(bus_if.locked), 64'd1);
      set_det(0, 1'b1, 20'd1000, 12'd100, 12'd300, 12'd50, 12'd200);
      run_frame("t2.back");
      clear_det();
      for (int k = 0; k < 4; k++) run_frame("t2.drop");
      check_val("t2.dropped", 64'(bus_if.locked), 64'd0);

      // 3: tie goes to red; a larger green count takes over
      set_det(0, 1'b1, 20'd800, 12'd10, 12'd20, 12'd30, 12'd40);
      set_det(1, 1'b1, 20'd800, 12'd500, 12'd600, 12'd700, 12'd800);
      for (int k = 0; k < 3; k++) run_frame("t3.tie");
      check_val("t3.tie_red", 64'(bus_if.red_en), 64'd1);
      f_cnt[1] = 20'd801;
      run_frame("t3.g1");
      check_val("t3.g1_off", 64'(bus_if.locked), 64'd0);
      run_frame("t3.g2");
      run_frame("t3.g3");
      check_val("t3.green", 64'(bus_if.grenn_en), 64'd1);
      check_val("t3.green_rt", 64'(bus_if.r_t), 64'h00ff00);

      // 4: low count or degenerate box never qualifies
      clear_det();
      for (int k = 0; k < 4; k++) run_frame("t4.idle");
      set_det(2, 1'b1, MIN_PIX - 20'd1, 12'd10, 12'd90, 12'd10, 12'd90);
      for (int k = 0; k < 3; k++) run_frame("t4.low");
      set_det(2, 1'b1, 20'd1000, 12'd120, 12'd120, 12'd10, 12'd90);
      for (int k = 0; k < 3; k++) run_frame("t4.degen");
      check_val("t4.blue_off", 64'(bus_if.blue_en), 64'd0);

      // 5: alternating winners never lock
      clear_det();
      for (int k = 0; k < 6; k++) begin
         clear_det();
         set_det(k % 2, 1'b1, 20'd1000, 12'd1, 12'd2, 12'd3, 12'd4);
         run_frame("t5.alt");
      end
      check_val("t5.never", 64'(bus_if.locked), 64'd0);

      // short frame: second boundary inside the pipeline is ignored
      clear_det();
      set_det(0, 1'b1, 20'd900, 12'd5, 12'd6, 12'd7, 12'd8);
      @(negedge clk);
      bus_if.i_vsync = 1'b0;
      apply_inputs();
      repeat (3) @(negedge clk);
      bus_if.i_vsync = 1'b1;
      model_frame();
      @(negedge clk);
      check_val("short.ack", 64'(bus_if.det_ack), 64'(f_vld));
      bus_if.i_vsync = 1'b0;
      @(negedge clk);
      check_outputs("short.out");
      bus_if.i_vsync = 1'b1;
      bus_if.det_vld = 3'b111;
      @(negedge clk);
      check_val("short.no_ack", 64'(bus_if.det_ack), 64'd0);
      repeat (3) @(negedge clk);
      check_outputs("short.hold");

      // 6: reset at B+1 while locked aborts, next boundary starts from IDLE
      clear_det();
      set_det(0, 1'b1, 20'd1000, 12'd100, 12'd300, 12'd50, 12'd200);
      for (int k = 0; k < 3; k++) run_frame("t6.lock");
      check_val("t6.locked", 64'(bus_if.locked), 64'd1);
      @(negedge clk);
      bus_if.i_vsync = 1'b0;
      apply_inputs();
      repeat (3) @(negedge clk);
      bus_if.i_vsync = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check_outputs("t6.rst");
      check_val("t6.rst_ack", 64'(bus_if.det_ack), 64'd0);
      reset = 1'b0;
      run_frame("t6.after1");
      check_val("t6.after1_off", 64'(bus_if.locked), 64'd0);
      run_frame("t6.after2");
      run_frame("t6.after3");

      // randomized frames with a slowly changing favoured detector
      fav = 0;
      for (int n = 0; n < 160; n++) begin
         if (n % 12 == 0) fav = int'($urandom_range(0, 3));
         for (int i = 0; i < 3; i++) begin
            hl = int'($urandom_range(0, 3000));
            vl = int'($urandom_range(0, 3000));
            f_hl[i] = 12'(hl);
            f_vl[i] = 12'(vl);
            f_hr[i] = 12'(hl + (($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 900))));
            f_vr[i] = 12'(vl + (($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 900))));
            if (i == fav) begin
               f_vld[i] = 1'b1;
               f_cnt[i] = 20'($urandom_range(700, 1500));
            end else begin
               f_vld[i] = 1'($urandom);
               f_cnt[i] = 20'($urandom_range(0, 900));
            end
         end
         if (fav == 3 && $urandom_range(0, 1) == 1) f_vld = 3'b000;
         if ($urandom_range(0, 9) == 0) f_cnt[1] = f_cnt[0];
         run_frame("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
